// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared constants for the register-watch FIFO: default geometry, drop-counter
// sizing and the stored-entry width formula.
//
// Optional feature macro: REG_WATCH_TIMESTAMP_EN
//   When defined, every stored entry carries a TS_W-bit cycle stamp above the
//   data bits, so the entry width becomes DATA_W + TS_W.
// -----------------------------------------------------------------------------
package watch_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int TS_W_DEF   = 16;

  localparam int                    DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = DROP_CNT_W'(255);

`ifdef REG_WATCH_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Width of one FIFO entry: the stamp (if any) sits above the data.
  function automatic int entry_width(int data_w, int ts_w);
    return TS_EN ? (data_w + ts_w) : data_w;
  endfunction

endpackage : watch_pkg

// File: rtl/sync_fifo_core.sv
// -----------------------------------------------------------------------------
// sync_fifo_core
// Generic single-clock FIFO with a registered show-ahead head. The head entry
// is held in an output register so o_data/o_valid come straight from flops.
// A write in cycle N is visible at the head in N+1 (no bypass), and after a
// pop the next entry appears on the following cycle with no bubble.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push         push request (dropped when full without a pop)
//   i_push_data    entry to store
//   i_ready        sink accepts the head entry this cycle
//   o_valid        head entry available
//   o_data         head entry (holds its last value while o_valid=0)
//   o_level        occupancy 0..DEPTH
//   o_drop         push request rejected this cycle (full, no pop)
//
// Parameters: W = entry width, DEPTH = entries (power of two, >= 2).
// -----------------------------------------------------------------------------
module sync_fifo_core #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_data,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_valid;
  logic [W-1:0]     r_data;

  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [LVL_W-1:0] w_level_nxt;
  logic [LVL_W-1:0] w_remain;
  logic [W-1:0]     w_head_nxt;

  assign w_pop  = r_valid && i_ready;
  assign w_full = (r_level == LVL_W'(DEPTH));
  // A pop frees the slot the push needs, so full+pop still accepts the push.
  assign w_wr   = i_push && (!w_full || w_pop);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_level_nxt = r_level;
    w_rptr_nxt  = r_rptr + PTR_W'(w_pop);
    w_remain    = r_level - LVL_W'(w_pop);
    w_head_nxt  = r_data;
    unique case ({w_wr, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
    // If nothing older survives this cycle's pop, the new head is the entry
    // being written right now; otherwise it is already in memory.
    if (w_remain == '0) begin
      if (w_wr) w_head_nxt = i_push_data;
    end else begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  // NOTE: storage has no reset; validity is tracked by the pointers and level,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
      r_rptr  <= w_rptr_nxt;
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
      r_data  <= w_head_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_level = r_level;
  assign o_drop  = i_push && !w_wr;

endmodule : sync_fifo_core

// File: rtl/reg_watch_fifo.sv
// -----------------------------------------------------------------------------
// reg_watch_fifo
// Watches one 8-bit register/ALU bus and logs value changes (or every
// qualified sample) into a FIFO drained through a valid/ready port. Tracks
// dropped pushes with a sticky overflow flag and a saturating drop counter.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   sample_en      qualifies data_in this cycle
//   capture_all    1: push every qualified sample, 0: push only on change
//   data_in        watched bus value
//   out_valid      head entry available
//   out_ready      sink accepts the head entry
//   out_data       head entry value
//   level          occupancy 0..DEPTH
//   overflow       sticky: at least one push was dropped
//   clr_overflow   clears overflow and drop_cnt (a same-cycle drop wins)
//   drop_cnt       saturating count of dropped pushes
//   out_ts         (REG_WATCH_TIMESTAMP_EN only) stamp of the head entry
//
// Optional feature macro: REG_WATCH_TIMESTAMP_EN adds a free-running TS_W-bit
// cycle counter whose value at sample time is stored with each entry.
// -----------------------------------------------------------------------------
module reg_watch_fifo #(
  parameter int DATA_W = watch_pkg::DATA_W_DEF,
  parameter int DEPTH  = watch_pkg::DEPTH_DEF,
  parameter int TS_W   = watch_pkg::TS_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sample_en,
  input  logic                              capture_all,
  input  logic [DATA_W-1:0]                 data_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic [$clog2(DEPTH):0]            level,
  output logic                              overflow,
  input  logic                              clr_overflow,
`ifdef REG_WATCH_TIMESTAMP_EN
  output logic [TS_W-1:0]                   out_ts,
`endif
  output logic [watch_pkg::DROP_CNT_W-1:0]  drop_cnt
);

  import watch_pkg::*;

  localparam int ENTRY_W = entry_width(DATA_W, TS_W);

  logic [DATA_W-1:0]     r_last_seen;
  logic                  r_last_seen_vld;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_push_req;
  logic                  w_drop;
  logic [ENTRY_W-1:0]    w_entry_in;
  logic [ENTRY_W-1:0]    w_entry_out;

  // Change detector: the first qualified sample after reset always pushes.
  assign w_push_req = sample_en &&
                      (capture_all || !r_last_seen_vld || (data_in != r_last_seen));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_seen     <= '0;
      r_last_seen_vld <= 1'b0;
    end else if (sample_en) begin
      // Tracks the bus even when the push is dropped, so a burst of drops
      // does not turn into a burst of stale "changes" later.
      r_last_seen     <= data_in;
      r_last_seen_vld <= 1'b1;
    end
  end

`ifdef REG_WATCH_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + TS_W'(1);
  end

  assign w_entry_in = {r_ts, data_in};
  assign out_ts     = w_entry_out[ENTRY_W-1 -: TS_W];
`else
  assign w_entry_in = data_in;
`endif

  sync_fifo_core #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push_req),
    .i_push_data (w_entry_in),
    .i_ready     (out_ready),
    .o_valid     (out_valid),
    .o_data      (w_entry_out),
    .o_level     (level),
    .o_drop      (w_drop)
  );

  // A drop in the same cycle as clr_overflow wins: the flag stays set and the
  // counter restarts at one rather than zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_overflow)                    r_drop_cnt <= DROP_CNT_W'(1);
      else if (r_drop_cnt != DROP_CNT_MAX) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign out_data = w_entry_out[DATA_W-1:0];
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule : reg_watch_fifo

// File: tb/tb_reg_watch_fifo.sv
// -----------------------------------------------------------------------------
// tb_reg_watch_fifo
// Self-checking bench for reg_watch_fifo: a hand-computed vector table, a few
// hand-written corner sequences, and a randomized run compared against a
// queue-based behavioural model. Inputs change on the falling edge, outputs
// are compared on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_reg_watch_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_en;
  logic              capture_all;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        level;
  logic              overflow;
  logic              clr_overflow;
  logic [7:0]        drop_cnt;
`ifdef REG_WATCH_TIMESTAMP_EN
  logic [TS_W-1:0]   out_ts;
`endif

  always #5 clk = ~clk;

  reg_watch_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .capture_all  (capture_all),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
`ifdef REG_WATCH_TIMESTAMP_EN
    .out_ts       (out_ts),
`endif
    .drop_cnt     (drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_last;
  bit                m_last_vld;
  bit                m_ovf;
  int                m_drop;
  logic [DATA_W-1:0] m_shown;

  task automatic model_reset();
    m_q.delete();
    m_last = '0; m_last_vld = 0; m_ovf = 0; m_drop = 0; m_shown = '0;
  endtask

  task automatic model_update();
    bit pop, req, drop;
    pop  = (m_q.size() > 0) && out_ready;
    req  = sample_en && (capture_all || !m_last_vld || data_in != m_last);
    drop = req && (m_q.size() == DEPTH) && !pop;
    if (sample_en) begin m_last = data_in; m_last_vld = 1; end
    if (pop) void'(m_q.pop_front());
    if (req && !drop) m_q.push_back(data_in);
    if (drop) begin
      m_ovf  = 1;
      m_drop = clr_overflow ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clr_overflow) begin
      m_ovf = 0; m_drop = 0;
    end
    if (m_q.size() > 0) m_shown = m_q[0];
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"},    out_valid, m_q.size() > 0);
    check({tag, ".data"},     out_data,  m_shown);
    check({tag, ".level"},    level,     m_q.size());
    check({tag, ".overflow"}, overflow,  m_ovf);
    check({tag, ".drop_cnt"}, drop_cnt,  m_drop);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic se, input logic ca, input logic [7:0] d,
                        input logic rdy, input logic clr);
    sample_en = se; capture_all = ca; data_in = d; out_ready = rdy; clr_overflow = clr;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       se, ca;
    logic [7:0] d;
    logic       rdy, clr;
    logic       ev;
    logic [7:0] ed;
    int         el;
    logic       eo;
    int         edc;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_drain[$];
  int         t1, t2;

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 8'h00, 0, 0);

    // se ca d  rdy clr | valid data level ovf drop
    vecs.push_back('{1, 0, 8'd0, 0, 0, 1, 8'd0, 1, 0, 0});
    vecs.push_back('{1, 0, 8'd0, 0, 0, 1, 8'd0, 1, 0, 0});
    vecs.push_back('{1, 0, 8'd1, 0, 0, 1, 8'd0, 2, 0, 0});
    vecs.push_back('{1, 0, 8'd1, 0, 0, 1, 8'd0, 2, 0, 0});
    vecs.push_back('{1, 0, 8'd2, 0, 0, 1, 8'd0, 3, 0, 0});
    vecs.push_back('{0, 0, 8'd0, 1, 0, 1, 8'd1, 2, 0, 0});
    vecs.push_back('{0, 0, 8'd0, 1, 0, 1, 8'd2, 1, 0, 0});
    vecs.push_back('{0, 0, 8'd0, 1, 0, 0, 8'd2, 0, 0, 0});
    vecs.push_back('{0, 0, 8'd0, 1, 0, 0, 8'd2, 0, 0, 0});
    for (int k = 1; k <= 5; k++) vecs.push_back('{1, 1, 8'd7, 0, 0, 1, 8'd7, k, 0, 0});
    for (int k = 4; k >= 0; k--) vecs.push_back('{0, 0, 8'd0, 1, 0, k > 0, 8'd7, k, 0, 0});
    vecs.push_back('{1, 0, 8'd9, 1, 0, 1, 8'd9, 1, 0, 0});
    vecs.push_back('{1, 0, 8'd9, 1, 0, 0, 8'd9, 0, 0, 0});
    vecs.push_back('{0, 0, 8'd0, 0, 1, 0, 8'd9, 0, 0, 0});

    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset.valid", out_valid, 0);
    check("reset.data",  out_data,  0);
    check("reset.level", level,     0);
    check("reset.ovf",   overflow,  0);
    check("reset.drop",  drop_cnt,  0);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].se, vecs[i].ca, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      step();
      check($sformatf("vec%0d.valid", i), out_valid, vecs[i].ev);
      check($sformatf("vec%0d.data", i),  out_data,  vecs[i].ed);
      check($sformatf("vec%0d.level", i), level,     vecs[i].el);
      check($sformatf("vec%0d.ovf", i),   overflow,  vecs[i].eo);
      check($sformatf("vec%0d.drop", i),  drop_cnt,  vecs[i].edc);
    end

    // ---- overflow: 20 distinct values into a 16-deep FIFO ----
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 0, 8'(40 + i), 0, 0);
      step();
      compare_model("fill");
    end
    check("fill.level", level,    16);
    check("fill.ovf",   overflow, 1);
    check("fill.drop",  drop_cnt, 4);

    // full + pop + distinct push in the same cycle
    set_in(1, 0, 8'd200, 1, 0);
    step();
    check("fullpop.level", level,    16);
    check("fullpop.ovf",   overflow, 1);
    check("fullpop.drop",  drop_cnt, 4);
    check("fullpop.data",  out_data, 41);

    // clear in the same cycle as a drop: set wins
    set_in(1, 0, 8'd201, 0, 1);
    step();
    check("clrdrop.ovf",  overflow, 1);
    check("clrdrop.drop", drop_cnt, 1);
    set_in(0, 0, 8'd0, 0, 1);
    step();
    check("clr.ovf",  overflow, 0);
    check("clr.drop", drop_cnt, 0);

    // drop counter saturation
    set_in(1, 1, 8'd5, 0, 0);
    for (int i = 0; i < 300; i++) step();
    check("sat.drop",  drop_cnt, 255);
    check("sat.ovf",   overflow, 1);
    check("sat.level", level,    16);

    // drain in order, one entry per cycle
    for (int v = 41; v <= 55; v++) exp_drain.push_back(8'(v));
    exp_drain.push_back(8'd200);
    set_in(0, 0, 8'd0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d.valid", i), out_valid, 1);
      check($sformatf("drain%0d.data", i),  out_data,  exp_drain[i]);
      step();
      compare_model("drain");
    end
    check("drain.empty", out_valid, 0);

    // ---- asynchronous reset mid-stream ----
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 8'(60 + i), 0, 0);
      step();
    end
    check("prerst.level", level, 5);
    set_in(0, 0, 8'd0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid", out_valid, 0);
    check("arst.level", level,     0);
    check("arst.data",  out_data,  0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 0, 8'd64, 0, 0);
    step();
    check("postrst.level", level,    1);
    check("postrst.data",  out_data, 64);
    compare_model("postrst");

`ifdef REG_WATCH_TIMESTAMP_EN
    // ---- timestamp spacing: samples four cycles apart ----
    apply_reset();
    set_in(1, 0, 8'd11, 0, 0); step();
    set_in(0, 0, 8'd0, 0, 0);  step(); step(); step();
    set_in(1, 0, 8'd12, 0, 0); step();
    set_in(0, 0, 8'd0, 0, 0);
    t1 = int'(out_ts);
    out_ready = 1'b1;
    step();
    t2 = int'(out_ts);
    check("ts.data",    out_data, 12);
    check("ts.spacing", 32'((t2 - t1) & 16'hFFFF), 4);
`endif

    // ---- randomized run against the model ----
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      int thr;
      thr = ((i / 500) % 2 == 0) ? 2 : 6;
      set_in(($urandom % 4) != 0, ($urandom % 4) == 0, 8'($urandom % 4),
             ($urandom % 8) < thr, ($urandom % 32) == 0);
      step();
      compare_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_reg_watch_fifo
